// File: rtl/core_fetch_redirect.sv
// Fetch sequencer: owns the fetch PC, issues word fetches and handles branch redirects,
// discarding wrong-path responses that are still in flight when a redirect lands.
module core_fetch_redirect #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch,
    input  logic [30:0] target,
    input  logic        queue_full,
    input  logic        mem_ready,
    input  logic        mem_rsp_valid,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    output logic [30:0] fetch_pc,
    output logic        rsp_keep,
    output logic        rsp_skip_low,
    output logic        flush
);

    localparam int unsigned      CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] outst;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] outst_next;
    logic             skip_arm;
    logic             accept;
    logic             ret;

    // A response with nothing outstanding is spurious and must not underflow the count.
    always_comb begin
        mem_req      = (state == ST_RUN) && !branch && !queue_full && (outst < MAX_CNT);
        accept       = mem_req && mem_ready;
        ret          = mem_rsp_valid && (outst != '0);
        outst_next   = outst + CNT_W'(accept) - CNT_W'(ret);
        rsp_keep     = (state == ST_RUN) && ret && !branch;
        rsp_skip_low = rsp_keep && skip_arm;
    end

    assign mem_addr = fetch_pc[30:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            fetch_pc <= '0;
            outst    <= '0;
            discard  <= '0;
            flush    <= 1'b0;
            skip_arm <= 1'b0;
        end else begin
            outst <= outst_next;
            flush <= branch;
            if (branch) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= target;
                discard  <= outst_next;
                skip_arm <= target[0];
                state    <= (outst_next == '0) ? ST_RUN : ST_DRAIN;
            end else begin
                if (accept) begin
                    fetch_pc <= {fetch_pc[30:1] + 30'd1, 1'b0};
                end
                case (state)
                    ST_RUN: begin
                        if (rsp_keep) begin
                            skip_arm <= 1'b0;
                        end
                    end
                    ST_DRAIN: begin
                        if (ret) begin
                            discard <= discard - 1'b1;
                            if (discard == CNT_W'(1)) begin
                                state <= ST_RUN;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    a_no_spurious_rsp: assert property (@(posedge clk) disable iff (rst)
        !(mem_rsp_valid && (outst == '0)));

endmodule

// File: tb/tb_core_fetch_redirect.sv
// Bench for core_fetch_redirect: directed vector table, hand sequences for redirect
// corner cases, then random traffic against an in-flight-queue reference model.
module tb_core_fetch_redirect;

    localparam int unsigned MAXO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch;
    logic [30:0] target;
    logic        queue_full;
    logic        mem_ready;
    logic        mem_rsp_valid;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic [30:0] fetch_pc;
    logic        rsp_keep;
    logic        rsp_skip_low;
    logic        flush;

    int errors = 0;
    int checks = 0;

    core_fetch_redirect #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk          (clk),
        .rst          (rst),
        .branch       (branch),
        .target       (target),
        .queue_full   (queue_full),
        .mem_ready    (mem_ready),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .fetch_pc     (fetch_pc),
        .rsp_keep     (rsp_keep),
        .rsp_skip_low (rsp_skip_low),
        .flush        (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        br;
        logic [30:0] tgt;
        logic        qf;
        logic        rdy;
        logic        rv;
        logic        e_req;
        logic [30:0] e_pc;
        logic        e_keep;
        logic        e_skip;
        logic        e_flush;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(logic br, logic [30:0] tgt, logic qf, logic rdy, logic rv,
                                logic e_req, logic [30:0] e_pc, logic e_keep, logic e_skip,
                                logic e_flush);
        vec_t v;
        v.br = br; v.tgt = tgt; v.qf = qf; v.rdy = rdy; v.rv = rv;
        v.e_req = e_req; v.e_pc = e_pc; v.e_keep = e_keep; v.e_skip = e_skip;
        v.e_flush = e_flush;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_req, input logic [30:0] e_pc,
                              input logic e_keep, input logic e_skip, input logic e_flush);
        logic [29:0] e_addr;
        e_addr = e_pc[30:1];
        chk({tag, ".mem_req"}, 32'(mem_req), 32'(e_req));
        chk({tag, ".fetch_pc"}, 32'(fetch_pc), 32'(e_pc));
        chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(e_addr));
        chk({tag, ".rsp_keep"}, 32'(rsp_keep), 32'(e_keep));
        chk({tag, ".rsp_skip_low"}, 32'(rsp_skip_low), 32'(e_skip));
        chk({tag, ".flush"}, 32'(flush), 32'(e_flush));
    endtask

    // Drive one cycle's inputs after the falling edge, check outputs before the rising edge.
    task automatic step(input string tag, input vec_t v);
        @(negedge clk);
        branch        = v.br;
        target        = v.tgt;
        queue_full    = v.qf;
        mem_ready     = v.rdy;
        mem_rsp_valid = v.rv;
        #1;
        check_outs(tag, v.e_req, v.e_pc, v.e_keep, v.e_skip, v.e_flush);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; branch = 1'b0; target = '0; queue_full = 1'b0;
        mem_ready = 1'b0; mem_rsp_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model: every in-flight fetch is an entry tagged wrong-path or not.
    bit          m_started;
    logic [30:0] m_pc;
    bit          m_flush;
    bit          m_skip;
    bit          m_q[$];

    function automatic void model_reset();
        m_started = 0; m_pc = '0; m_flush = 0; m_skip = 0; m_q.delete();
    endfunction

    initial begin
        vec_t sv;
        string tag;
        int wrong;
        bit e_req, e_keep, e_skip, acc;

        rst = 1'b1;
        do_reset();
        #1;
        check_outs("reset", 1'b0, 31'h0, 1'b0, 1'b0, 1'b0);

        vecs[0]  = mk(1, 31'h0,  0, 0, 0,  0, 31'h0,  0, 0, 0);
        vecs[1]  = mk(0, 31'h0,  0, 0, 0,  1, 31'h0,  0, 0, 1);
        vecs[2]  = mk(0, 31'h0,  0, 1, 0,  1, 31'h0,  0, 0, 0);
        vecs[3]  = mk(0, 31'h0,  0, 1, 0,  1, 31'h2,  0, 0, 0);
        vecs[4]  = mk(0, 31'h0,  0, 1, 0,  1, 31'h4,  0, 0, 0);
        vecs[5]  = mk(0, 31'h0,  0, 1, 0,  1, 31'h6,  0, 0, 0);
        vecs[6]  = mk(0, 31'h0,  0, 1, 0,  0, 31'h8,  0, 0, 0);
        vecs[7]  = mk(0, 31'h0,  0, 0, 1,  0, 31'h8,  1, 0, 0);
        vecs[8]  = mk(1, 31'h40, 0, 0, 0,  0, 31'h8,  0, 0, 0);
        vecs[9]  = mk(0, 31'h0,  0, 0, 1,  0, 31'h40, 0, 0, 1);
        vecs[10] = mk(0, 31'h0,  0, 0, 1,  0, 31'h40, 0, 0, 0);
        vecs[11] = mk(0, 31'h0,  0, 0, 1,  0, 31'h40, 0, 0, 0);
        vecs[12] = mk(0, 31'h0,  0, 0, 0,  1, 31'h40, 0, 0, 0);
        vecs[13] = mk(1, 31'h41, 0, 0, 0,  0, 31'h40, 0, 0, 0);
        vecs[14] = mk(0, 31'h0,  0, 1, 0,  1, 31'h41, 0, 0, 1);
        vecs[15] = mk(0, 31'h0,  0, 1, 0,  1, 31'h42, 0, 0, 0);
        vecs[16] = mk(0, 31'h0,  0, 0, 1,  1, 31'h44, 1, 1, 0);
        vecs[17] = mk(0, 31'h0,  0, 0, 1,  1, 31'h44, 1, 0, 0);
        vecs[18] = mk(0, 31'h0,  1, 1, 0,  0, 31'h44, 0, 0, 0);
        vecs[19] = mk(0, 31'h0,  1, 1, 0,  0, 31'h44, 0, 0, 0);
        vecs[20] = mk(0, 31'h0,  0, 1, 0,  1, 31'h44, 0, 0, 0);
        vecs[21] = mk(0, 31'h0,  0, 0, 1,  1, 31'h46, 1, 0, 0);

        for (int i = 0; i < 22; i++) begin
            tag = $sformatf("vec%0d", i);
            step(tag, vecs[i]);
        end

        // Redirect while a response returns with two outstanding and mem_ready high.
        step("b5_acc0", mk(0, 31'h0,  0, 1, 0,  1, 31'h46, 0, 0, 0));
        step("b5_acc1", mk(0, 31'h0,  0, 1, 0,  1, 31'h48, 0, 0, 0));
        step("b5_br",   mk(1, 31'h80, 0, 1, 1,  0, 31'h4a, 0, 0, 0));
        step("b5_drop", mk(0, 31'h0,  0, 1, 1,  0, 31'h80, 0, 0, 1));
        step("b5_run",  mk(0, 31'h0,  0, 1, 0,  1, 31'h80, 0, 0, 0));
        step("b5_next", mk(0, 31'h0,  0, 0, 0,  1, 31'h82, 0, 0, 0));

        // Branch held two cycles: two redirects, flush high twice, last target wins.
        step("bh_0",    mk(1, 31'h10, 0, 0, 0,  0, 31'h82, 0, 0, 0));
        step("bh_1",    mk(1, 31'h12, 0, 0, 0,  0, 31'h10, 0, 0, 1));
        step("bh_drop", mk(0, 31'h0,  0, 0, 1,  0, 31'h12, 0, 0, 1));
        step("bh_run",  mk(0, 31'h0,  0, 0, 0,  1, 31'h12, 0, 0, 0));

        // Random traffic against the reference model; memory answers only what it accepted.
        do_reset();
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst           = ($urandom_range(0, 599) == 0);
            branch        = (c == 0) || ($urandom_range(0, 11) == 0);
            target        = 31'($urandom);
            queue_full    = ($urandom_range(0, 4) == 0);
            mem_ready     = 1'($urandom_range(0, 1));
            mem_rsp_valid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            #1;
            wrong = 0;
            foreach (m_q[k]) if (m_q[k]) wrong++;
            e_req  = m_started && (wrong == 0) && !branch && !queue_full && (m_q.size() < MAXO);
            e_keep = mem_rsp_valid && m_started && !branch && !m_q[0];
            e_skip = e_keep && m_skip;
            check_outs("rand", e_req, m_pc, e_keep, e_skip, m_flush);

            if (rst) begin
                model_reset();
            end else begin
                acc = e_req && mem_ready;
                if (mem_rsp_valid) void'(m_q.pop_front());
                if (acc) begin
                    m_q.push_back(1'b0);
                    m_pc = {m_pc[30:1] + 30'd1, 1'b0};
                end
                if (e_keep) m_skip = 0;
                m_flush = branch;
                if (branch) begin
                    foreach (m_q[k]) m_q[k] = 1'b1;
                    m_pc      = target;
                    m_skip    = target[0];
                    m_started = 1;
                end
            end
        end

        @(negedge clk);
        rst = 1'b0; branch = 1'b0; mem_rsp_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
